worley_noise_pipe: RTL
======================

Name: worley_noise_pipe

Overview:
- Parametrised, pipelined successor to the combinational Worley noise generator in the VGA example designs.
- Holds N_POINTS feature points as registers. Each point carries a signed velocity, moves once per frame and bounces off the screen edges.
- Computes nearest and second-nearest distance per pixel over a fixed 4-stage pipeline, in one of four modes.
- Sits between hvsync_generator (x/y/display_on) and the RGB mapping in the top level.

Parameters:
- N_POINTS, 4, number of feature points, legal range 1..8.
- H_ACTIVE, 640, active width; point x range is 0..H_ACTIVE-1.
- V_ACTIVE, 480, active height; point y range is 0..V_ACTIVE-1.
- DIST_SHIFT, 8, right shift applied to squared Euclidean distances.
- MAN_SHIFT, 1, right shift applied to Manhattan distances.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, issued once per frame during blanking.
- freeze  in  1  when high, point motion is held.
- mode  in  2  0=F1 Euclidean, 1=F1 Manhattan, 2=F2-F1 Euclidean, 3=cell-ID.
- valid_in  in  1  pixel qualifier (display_on).
- x  in  10  pixel column.
- y  in  10  pixel row.
- noise  out  8  noise value.
- valid_out  out  1  valid_in delayed by 4 cycles.

Behaviour:
- Reset: asynchronous, active-high; one clock; no other clock domains.
  - Point i position: px_i = (80+160*i) mod H_ACTIVE, py_i = (60+97*i) mod V_ACTIVE.
  - Point i velocity: vx_i = (i even ? +1 : -1) * (1 + i mod 3), vy_i = (i odd ? +1 : -1) * (1 + i mod 2). Velocities are 4-bit signed.
  - All pipeline registers clear; noise=0, valid_out=0.
- Motion, on frame_tick=1 and freeze=0, per point and per axis independently:
  - nx = px + vx, computed signed at 12 bits.
  - If nx < 0 or nx > H_ACTIVE-1: vx <= -vx and px is unchanged.
  - Otherwise px <= nx.
  - y uses the same rule with V_ACTIVE.
  - freeze=1 suppresses the update, including when it coincides with frame_tick.
- Pipeline: x, y, valid_in and mode are captured together and travel together; a mode change therefore takes effect per pixel with no glitch.
  - S1: per point, |dx| and |dy| (10-bit unsigned) from the current point registers.
  - S2: per point, Euclidean d = dx² + dy² (20-bit) or Manhattan d = dx + dy (11-bit, zero-extended), selected by the staged mode.
  - S3: find F1 (smallest d), F2 (second smallest) and ID (index of F1). Ties go to the lower index. If N_POINTS=1, F2 = all ones.
  - S4: output formatting, registered to noise.
- Output formatting:
  - sat8(v) = v > 255 ? 255 : v.
  - mode 0: noise = ~sat8(F1 >> DIST_SHIFT).
  - mode 1: noise = ~sat8(F1 >> MAN_SHIFT).
  - mode 2: noise = sat8((F2 - F1) >> DIST_SHIFT). Not inverted; F2 >= F1 always holds.
  - mode 3: noise = {ID[2:0], ~sat8(F1 >> DIST_SHIFT)[7:3]}.
- Latency: noise and valid_out correspond to the inputs presented exactly 4 cycles earlier.
  - The pipeline runs every cycle; noise is computed even when valid_in=0.
- Points are read live in S1. frame_tick must arrive in blanking; an update mid-line takes effect at the next S1 sample, with no hold-off.
- Reset mid-frame: everything returns to the reset state immediately. valid_out is 0 until 4 cycles after the first valid_in following reset release.

Test Plan:
- Reset with N_POINTS=4, mode 0, pixel (80,60) with valid_in=1 -> 4 cycles later noise=255, valid_out=1. valid_out is 0 for cycles 1-3.
- Mode 1, pixel (90,60) -> Manhattan 10 >> 1 = 5, so noise=250. Mode 2, pixel (160,60) -> F1=6400, F2=15809, so noise=(9409>>8)=36.
- Mode 3, pixel (240,157) -> ID=1, F1=0, so noise=8'b001_11111=0x3F. Stream modes 0,1,2,3 on consecutive cycles -> each output matches its own mode.
- One frame_tick: p0 moves to (81,59). Pixel (81,59), mode 0 -> noise=255. Assert frame_tick with freeze=1 -> p0 is unchanged.
- Apply 559 ticks -> p0.x=639. Tick 560 -> x stays 639, vx=-1. Tick 561 -> x=638. Y bounce checked analogously at py=0.
- Assert reset mid-stream with valid_in high -> noise=0 and valid_out=0 immediately, and points return to their reset positions. Also check N_POINTS=1 in mode 2 -> noise=255.

Source files
------------

// File: rtl/worley_noise_pipe.sv
// Worley noise generator: N_POINTS bouncing feature points and a 4-stage
// nearest/second-nearest distance pipeline producing one 8-bit value per pixel.
module worley_noise_pipe #(
    parameter int N_POINTS   = 4,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DIST_SHIFT = 8,
    parameter int MAN_SHIFT  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       freeze,
    input  logic [1:0] mode,
    input  logic       valid_in,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [7:0] noise,
    output logic       valid_out
);

    function automatic logic [9:0] init_pos(input int i, input int base, input int step, input int span);
        return 10'((base + step * i) % span);
    endfunction

    // pos_even selects whether even-indexed points start with a positive velocity
    function automatic logic signed [3:0] init_vel(input int i, input bit pos_even, input int modv);
        int mag;
        mag = 1 + (i % modv);
        if (((i % 2) == 0) == pos_even) begin
            return 4'(mag);
        end else begin
            return 4'(-mag);
        end
    endfunction

    function automatic logic [7:0] sat8(input logic [19:0] v);
        if (v > 20'd255) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

    logic [9:0]        px_r [N_POINTS];
    logic [9:0]        py_r [N_POINTS];
    logic signed [3:0] vx_r [N_POINTS];
    logic signed [3:0] vy_r [N_POINTS];
    logic [11:0]       nx_s [N_POINTS];
    logic [11:0]       ny_s [N_POINTS];
    logic              bounce_x_s [N_POINTS];
    logic              bounce_y_s [N_POINTS];

    logic [9:0]  adx_s [N_POINTS];
    logic [9:0]  ady_s [N_POINTS];
    logic [9:0]  adx_r [N_POINTS];
    logic [9:0]  ady_r [N_POINTS];
    logic [19:0] d_s [N_POINTS];
    logic [19:0] d_r [N_POINTS];
    logic [19:0] f1_s, f2_s, f1_r, f2_r;
    logic [2:0]  id_s, id_r;
    logic [1:0]  mode1_r, mode2_r, mode3_r;
    logic        valid1_r, valid2_r, valid3_r;
    logic [7:0]  eu_inv_s, noise_s;

    // Candidate next positions; a step outside the screen reflects the velocity instead
    always_comb begin
        for (int i = 0; i < N_POINTS; i++) begin
            nx_s[i] = {2'b00, px_r[i]} + {{8{vx_r[i][3]}}, vx_r[i]};
            ny_s[i] = {2'b00, py_r[i]} + {{8{vy_r[i][3]}}, vy_r[i]};
            bounce_x_s[i] = nx_s[i][11] || (nx_s[i][10:0] > 11'(H_ACTIVE - 1));
            bounce_y_s[i] = ny_s[i][11] || (ny_s[i][10:0] > 11'(V_ACTIVE - 1));
        end
    end

    // Point position/velocity registers, advanced once per unfrozen frame tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_POINTS; i++) begin
                px_r[i] <= init_pos(i, 80, 160, H_ACTIVE);
                py_r[i] <= init_pos(i, 60, 97, V_ACTIVE);
                vx_r[i] <= init_vel(i, 1'b1, 3);
                vy_r[i] <= init_vel(i, 1'b0, 2);
            end
        end else if (frame_tick && !freeze) begin
            for (int i = 0; i < N_POINTS; i++) begin
                if (bounce_x_s[i]) vx_r[i] <= -vx_r[i];
                else               px_r[i] <= nx_s[i][9:0];
                if (bounce_y_s[i]) vy_r[i] <= -vy_r[i];
                else               py_r[i] <= ny_s[i][9:0];
            end
        end
    end

    // S1 combinational: per-point absolute axis distances against live point positions
    always_comb begin
        for (int i = 0; i < N_POINTS; i++) begin
            if (x >= px_r[i]) adx_s[i] = x - px_r[i];
            else              adx_s[i] = px_r[i] - x;
            if (y >= py_r[i]) ady_s[i] = y - py_r[i];
            else              ady_s[i] = py_r[i] - y;
        end
    end

    // S2 combinational: Manhattan only for mode 1, every other mode uses squared Euclidean
    always_comb begin
        for (int i = 0; i < N_POINTS; i++) begin
            if (mode1_r == 2'd1) begin
                d_s[i] = {9'd0, {1'b0, adx_r[i]} + {1'b0, ady_r[i]}};
            end else begin
                d_s[i] = ({10'd0, adx_r[i]} * {10'd0, adx_r[i]}) + ({10'd0, ady_r[i]} * {10'd0, ady_r[i]});
            end
        end
    end

    // S3 combinational: running F1/F2 search, strict compare keeps the lower index on ties
    always_comb begin
        f1_s = '1;
        f2_s = '1;
        id_s = 3'd0;
        for (int i = 0; i < N_POINTS; i++) begin
            if (d_r[i] < f1_s) begin
                f2_s = f1_s;
                f1_s = d_r[i];
                id_s = 3'(i);
            end else if (d_r[i] < f2_s) begin
                f2_s = d_r[i];
            end else begin
                f2_s = f2_s;
            end
        end
    end

    // S4 combinational: mode-dependent output formatting
    always_comb begin
        eu_inv_s = ~sat8(f1_r >> DIST_SHIFT);
        case (mode3_r)
            2'd0:    noise_s = eu_inv_s;
            2'd1:    noise_s = ~sat8(f1_r >> MAN_SHIFT);
            2'd2:    noise_s = sat8((f2_r - f1_r) >> DIST_SHIFT);
            2'd3:    noise_s = {id_r, eu_inv_s[7:3]};
            default: noise_s = 8'd0;
        endcase
    end

    // Pipeline registers; mode and valid travel alongside their pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_POINTS; i++) begin
                adx_r[i] <= 10'd0;
                ady_r[i] <= 10'd0;
                d_r[i]   <= 20'd0;
            end
            mode1_r   <= 2'd0;
            mode2_r   <= 2'd0;
            mode3_r   <= 2'd0;
            valid1_r  <= 1'b0;
            valid2_r  <= 1'b0;
            valid3_r  <= 1'b0;
            f1_r      <= 20'd0;
            f2_r      <= 20'd0;
            id_r      <= 3'd0;
            noise     <= 8'd0;
            valid_out <= 1'b0;
        end else begin
            for (int i = 0; i < N_POINTS; i++) begin
                adx_r[i] <= adx_s[i];
                ady_r[i] <= ady_s[i];
                d_r[i]   <= d_s[i];
            end
            mode1_r   <= mode;
            valid1_r  <= valid_in;
            mode2_r   <= mode1_r;
            valid2_r  <= valid1_r;
            f1_r      <= f1_s;
            f2_r      <= f2_s;
            id_r      <= id_s;
            mode3_r   <= mode2_r;
            valid3_r  <= valid2_r;
            noise     <= noise_s;
            valid_out <= valid3_r;
        end
    end

endmodule
